// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  muldiv_unit_pkg
//  Op codes and controller state encodings shared by the mul/div stage.
//  Revision: 1.0
// ============================================================================
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHU and REMU both read the upper half of the shared accumulator.
  function automatic logic op_selects_hi(input op_e op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_step.sv
`default_nettype none
// ============================================================================
//  muldiv_step
//  One radix-2 iteration: shift-add multiply or restoring-divide step.
//  Revision: 1.0
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder shifted left with the next dividend bit appended.
    trial    = acc[2*WIDTH-1:WIDTH-1];
    ge       = (trial >= {1'b0, operand});
    rem_next = ge ? WIDTH'(trial - {1'b0, operand}) : trial[WIDTH-1:0];
    acc_next = is_div ? {rem_next, acc[WIDTH-2:0], ge}
                      : {sum, acc[WIDTH-1:1]};
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  muldiv_unit
//  Multi-cycle unsigned MUL/MULHU/DIVU/REMU with register-file writeback.
//  Revision: 1.0
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [REGBITS-1:0] dest,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic [REGBITS-1:0]   dest_q, dest_d;
  logic [REGBITS-1:0]   wa_q, wa_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     wd_q, wd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 div_sel;
  op_e                  op_in;

  assign op_in   = op_e'(op);
  assign div_sel = op_is_div(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_sel),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dest_d  = dest_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_in;
          dest_d  = dest;
          cnt_d   = '0;
          state_d = ST_RUN;
          // Multiply iterates over b with a as addend; divide shifts a out under b.
          if (op_is_div(op_in)) begin
            opnd_d = b;
            acc_d  = {{WIDTH{1'b0}}, a};
          end else begin
            opnd_d = a;
            acc_d  = {{WIDTH{1'b0}}, b};
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WB;
          wa_d    = dest_q;
          wd_d    = op_selects_hi(op_q) ? step_acc[2*WIDTH-1:WIDTH]
                                        : step_acc[WIDTH-1:0];
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      dest_q  <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  // A reset arriving during WB must suppress that cycle's write as well.
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_WB) && !reset;
  assign regwrite = done && (wa_q != '0);
  assign wa       = wa_q;
  assign wd       = wd_q;

endmodule
`default_nettype wire
